pipe_hazard_ctrl: RTL

//   Parametrised pipeline hazard controller; successor to the fixed 5-stage stall priority encoder.

---
 rtl/pipe_hazard_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: per-stage stall/bubble/flush generation for an
// N-stage in-order core. It holds a flush that an older-stage stall blocks,
// runs a stall watchdog and keeps saturating performance counters.
// Stage 0 is IF (youngest); stage NUM_STAGES-1 is WB (oldest).
module pipe_hazard_ctrl #(
    parameter int NUM_STAGES = 5,
    parameter int SW         = 3,
    parameter int CNT_W      = 32,
    parameter int WDOG_LIMIT = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] stall_req_i,
    input  logic                  flush_req_i,
    input  logic [SW-1:0]         flush_stage_i,
    input  logic                  wdog_clr_i,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic [NUM_STAGES-1:0] bubble_o,
    output logic [NUM_STAGES-1:0] flush_o,
    output logic                  flush_pend_o,
    output logic                  wdog_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    localparam int WDW = $clog2(WDOG_LIMIT + 1);
    localparam logic [WDW-1:0] WLIM = WDW'(WDOG_LIMIT);

    typedef enum logic {
        IDLE,
        FLUSH_PEND
    } state_t;

    state_t                state;
    logic [SW-1:0]         pend_stage;
    logic [WDW-1:0]        wdog_cnt;

    logic                  stall_any;
    logic [SW-1:0]         hi;
    logic                  stage_ok;
    logic [SW-1:0]         f_eff;
    logic                  f_valid;
    logic                  f_block;
    logic                  f_apply;
    logic [NUM_STAGES-1:0] stall_v;
    logic [NUM_STAGES-1:0] bubble_v;
    logic [NUM_STAGES-1:0] flush_v;
    logic                  stall_active;

    // Priority encode: the oldest stalling stage determines the stall boundary.
    always_comb begin
        stall_any = 1'b0;
        hi        = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (stall_req_i[i]) begin
                stall_any = 1'b1;
                hi        = SW'(i);
            end
        end
    end

    // Effective flush stage: a held flush merges with a new one, the older stage wins.
    // An out-of-range new request never disturbs a held flush.
    always_comb begin
        stage_ok = (flush_stage_i != '0) && (int'(flush_stage_i) < NUM_STAGES);
        f_eff    = '0;
        if (state == IDLE) begin
            if (flush_req_i) f_eff = flush_stage_i;
        end else begin
            f_eff = pend_stage;
            if (flush_req_i && stage_ok && (flush_stage_i > pend_stage)) f_eff = flush_stage_i;
        end
        f_valid = (f_eff != '0) && (int'(f_eff) < NUM_STAGES);
        f_block = f_valid && stall_any && (hi >= f_eff);
        f_apply = f_valid && !f_block;
    end

    // Build stall/bubble/flush vectors; an applied flush wins over younger-stage stalls.
    always_comb begin
        stall_v  = '0;
        bubble_v = '0;
        flush_v  = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            stall_v[i] = stall_any && (SW'(i) <= hi);
            if (i > 0) bubble_v[i] = stall_any && (SW'(i - 1) == hi);
            flush_v[i] = f_apply && (SW'(i) < f_eff);
        end
        stall_v  = stall_v & ~flush_v;
        bubble_v = bubble_v & ~flush_v;
    end

    // Reset blanks the combinational control outputs immediately.
    always_comb begin
        stall_o  = rst ? '0 : stall_v;
        bubble_o = rst ? '0 : bubble_v;
        flush_o  = rst ? '0 : flush_v;
    end

    assign stall_active = |stall_v;
    assign flush_pend_o = (state == FLUSH_PEND);

    // Flush FSM: hold a blocked flush until no older stage stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pend_stage <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (f_block) begin
                        state      <= FLUSH_PEND;
                        pend_stage <= f_eff;
                    end
                end
                FLUSH_PEND: begin
                    if (f_apply) begin
                        state      <= IDLE;
                        pend_stage <= '0;
                    end else if (f_block) begin
                        pend_stage <= f_eff;
                    end
                end
                default: begin
                    state      <= IDLE;
                    pend_stage <= '0;
                end
            endcase
        end
    end

    // Watchdog: count consecutive stall cycles; trip is sticky until cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt <= '0;
            wdog_o   <= 1'b0;
        end else if (wdog_clr_i) begin
            wdog_cnt <= '0;
            wdog_o   <= 1'b0;
        end else if (!stall_active) begin
            wdog_cnt <= '0;
        end else if (wdog_cnt != WLIM) begin
            wdog_cnt <= wdog_cnt + WDW'(1);
            if (wdog_cnt + WDW'(1) == WLIM) wdog_o <= 1'b1;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_active && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (f_apply && (flush_cnt_o != '1)) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
        end
    end

endmodule
